dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and access sequencer for the shared data memory. Port 0 is the pipeline MEM stage; port 1 is a secondary master (debug/loader DMA). The block serialises word accesses into a fixed-latency memory window, returns read data with a one-cycle acknowledge, and drives a stall to freeze the pipeline while a MEM-stage access is outstanding. Starvation of port 1 is bounded by a configurable grant limit.

## Interface
- MEM_LAT, 2: access window length in cycles, ≥1.
- STARVE_LIM, 4: consecutive port-0 grants allowed while port 1 waits, ≥1.

- clk_i  in  1  clock, rising edge.
- start_i  in  1  asynchronous, active-low reset.
- req0_i, req1_i  in  1  access request, level, held until matching ack.
- we0_i, we1_i  in  1  1 = write, 0 = read.
- addr0_i, addr1_i  in  32  byte address; bits [1:0] ignored.
- wdata0_i, wdata1_i  in  32  write data.
- ack0_o, ack1_o  out  1  one-cycle completion pulse.
- rdata0_o, rdata1_o  out  32  read data, registered per port.
- stall_o  out  1  pipeline freeze = req0_i & ~ack0_o (combinational).
- busy_o  out  1  high in BUSY or DONE.
- mem_en_o  out  1  memory enable, high in every BUSY cycle.
- mem_we_o  out  1  write strobe, high only in last BUSY cycle of a write.
- mem_addr_o  out  32  {addr[31:2], 2'b00} of granted port.
- mem_wdata_o  out  32  wdata of granted port.
- mem_rdata_i  in  32  memory read data (combinational from mem_addr_o).

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: if any req, latch grant (gnt), we, addr, wdata of winner; cnt <= MEM_LAT-1; -> BUSY. Else stay.
- Arbitration at IDLE decision: req1 only -> port 1; req0 only -> port 0; both -> port 0 unless starve == STARVE_LIM, then port 1.
- starve: port 0 granted while req1_i high -> starve+1 (saturate at STARVE_LIM); port 1 granted or req1_i low at decision -> 0.
- BUSY: mem_en_o=1, mem_addr_o/mem_wdata_o from latched values. cnt>0 -> cnt-1. cnt==0 -> mem_we_o=latched we; on the edge, if read, rdata[gnt] <= mem_rdata_i; -> DONE.
- DONE: ack[gnt]_o=1 for exactly this cycle; -> IDLE unconditionally.
- Requester must drop req on the edge ending its ack cycle; req still high in IDLE is a new request.
- Request inputs ignored in BUSY/DONE; latched values used; changes to addr/wdata mid-access have no effect.
- rdataN_o holds last read value until next read completion on that port; writes do not change it.
- Each write performs exactly one mem_we_o cycle.

## Timing
- Reset (start_i low, async): state IDLE, cnt 0, starve 0, gnt 0, ack0_o=ack1_o=0, rdata0_o=rdata1_o=0, mem_en_o=mem_we_o=0, mem_addr_o=mem_wdata_o=0, busy_o=0. stall_o follows req0_i.
- Reset mid-access: access abandoned, no ack; write committed only if mem_we_o edge already passed.
- Request sampled at edge E (in IDLE): BUSY cycles E..E+MEM_LAT-1, ack high in cycle after edge E+MEM_LAT, IDLE after edge E+MEM_LAT+1.
- Back-to-back throughput: one access per MEM_LAT+2 cycles.
- stall_o: high from req0 assertion through the cycle before ack0_o; low in ack cycle so pipeline advances on that edge.
- Simultaneous req0/req1 arrival in IDLE: port 0 wins unless starve limit reached.

## Test plan
- Single port-0 read, MEM_LAT=2, memory word 0x00 = 5: req0 at edge 0 -> mem_en_o cycles 0-1, ack0_o cycle 2, rdata0_o=5, stall_o high cycles 0-1, low cycle 2.
- Port-1 write 0x1c=0xDEADBEEF then port-0 read 0x1c -> exactly one mem_we_o pulse, rdata0_o=0xDEADBEEF, rdata1_o stays 0.
- Both requesters held continuously, STARVE_LIM=4 -> grant sequence 0,0,0,0,1,0,0,0,0,1; acks spaced MEM_LAT+2 cycles.
- Address 0x07 on port 0 -> mem_addr_o=0x04.
- Reset asserted in second BUSY cycle of a write with MEM_LAT=3 -> no mem_we_o, no ack, all outputs at reset values, next request served normally.
- req0 raised in DONE of a port-1 access -> ignored until IDLE, granted next edge, stall_o high throughout.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: serialises word accesses into a fixed MEM_LAT-cycle window,
// acks with a one-cycle pulse and bounds port-1 starvation by STARVE_LIM consecutive port-0 wins.
module dmem_arbiter #(
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic        clk_i,
    input  logic        start_i,
    input  logic        req0_i,
    input  logic        req1_i,
    input  logic        we0_i,
    input  logic        we1_i,
    input  logic [31:0] addr0_i,
    input  logic [31:0] addr1_i,
    input  logic [31:0] wdata0_i,
    input  logic [31:0] wdata1_i,
    output logic        ack0_o,
    output logic        ack1_o,
    output logic [31:0] rdata0_o,
    output logic [31:0] rdata1_o,
    output logic        stall_o,
    output logic        busy_o,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int unsigned StvW = $clog2(STARVE_LIM + 1);
    localparam logic [CntW-1:0] CntInit = CntW'(MEM_LAT - 1);
    localparam logic [StvW-1:0] StvLim  = StvW'(STARVE_LIM);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [StvW-1:0]  starve_q, starve_d;
    logic             gnt_q, gnt_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata0_q, rdata0_d;
    logic [31:0]      rdata1_q, rdata1_d;
    logic             any_req;
    logic             win1;

    assign any_req = req0_i | req1_i;
    // Port 1 wins when alone, or when port 0 has used up its consecutive-grant allowance.
    assign win1    = req1_i & (~req0_i | (starve_q == StvLim));

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            starve_q <= '0;
            gnt_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            gnt_q    <= gnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (any_req) state_d = StBusy;
            StBusy:  if (cnt_q == '0) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        starve_d = starve_q;
        gnt_d    = gnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        if (state_q == StIdle && any_req) begin
            gnt_d   = win1;
            we_d    = win1 ? we1_i : we0_i;
            addr_d  = (win1 ? addr1_i : addr0_i) & 32'hFFFF_FFFC;
            wdata_d = win1 ? wdata1_i : wdata0_i;
            cnt_d   = CntInit;
            if (!win1 && req1_i) begin
                starve_d = (starve_q == StvLim) ? starve_q : starve_q + 1'b1;
            end else begin
                starve_d = '0;
            end
        end else if (state_q == StBusy) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else if (!we_q) begin
                if (gnt_q) rdata1_d = mem_rdata_i;
                else       rdata0_d = mem_rdata_i;
            end
        end
    end

    always_comb begin
        mem_en_o = (state_q == StBusy);
        mem_we_o = (state_q == StBusy) && (cnt_q == '0) && we_q;
        ack0_o   = (state_q == StDone) && !gnt_q;
        ack1_o   = (state_q == StDone) && gnt_q;
        busy_o   = (state_q == StBusy) || (state_q == StDone);
    end

    assign stall_o     = req0_i & ~ack0_o;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign rdata0_o    = rdata0_q;
    assign rdata1_o    = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised scoreboard bench for dmem_arbiter: a transaction-level model predicts grant order,
// read data and write count; a negedge monitor checks every ack against the queued expectation.
module tb_dmem_arbiter;

    localparam int unsigned LAT = 3;
    localparam int unsigned LIM = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, stall, busy, mem_en, mem_we;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

    dmem_arbiter #(.MEM_LAT(LAT), .STARVE_LIM(LIM)) dut (
        .clk_i(clk), .start_i(rst_n),
        .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
        .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
        .ack0_o(ack0), .ack1_o(ack1), .rdata0_o(rdata0), .rdata1_o(rdata1),
        .stall_o(stall), .busy_o(busy), .mem_en_o(mem_en), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory behind the arbiter: 16 words, combinational read, written on the clock edge.
    logic [31:0] mem [16];
    assign mem_rdata = mem[mem_addr[5:2]];
    always @(posedge clk) if (mem_en && mem_we) mem[mem_addr[5:2]] <= mem_wdata;

    typedef struct {
        int          port;
        logic [31:0] r0;
        logic [31:0] r1;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] mmem [16];
    logic [31:0] last_rd [2];
    int          starve_m = 0;
    int          writes_m = 0;
    int          we_cnt = 0;
    int          total = 0;
    int          bad = 0;
    bit          mon_on = 1'b0;

    bit          p [2];
    logic        we_r [2];
    logic [31:0] a_r [2];
    logic [31:0] d_r [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            chk("stall", {31'd0, stall}, {31'd0, req0 & ~ack0});
            if (mem_we) we_cnt++;
            if (ack0 || ack1) begin
                if (expq.size() == 0) begin
                    chk("unexpected_ack", {30'd0, ack1, ack0}, 32'd0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("ack_port", {30'd0, ack1, ack0}, (e.port == 1) ? 32'd2 : 32'd1);
                    chk("rdata0", rdata0, e.r0);
                    chk("rdata1", rdata1, e.r1);
                end
            end
        end
    end

    task automatic drive_pins();
        req0 = p[0]; we0 = we_r[0]; addr0 = a_r[0]; wdata0 = d_r[0];
        req1 = p[1]; we1 = we_r[1]; addr1 = a_r[1]; wdata1 = d_r[1];
    endtask

    task automatic new_req(input int port, input logic we, input logic [31:0] a,
                           input logic [31:0] d);
        p[port] = 1'b1; we_r[port] = we; a_r[port] = a; d_r[port] = d;
    endtask

    task automatic rnd_req(input int port);
        new_req(port, 1'($urandom_range(0, 1)), $urandom, $urandom);
    endtask

    // Entered #1 after a rising edge with the DUT idle; returns #1 after the edge ending the ack.
    task automatic do_access();
        int          win;
        int          n;
        logic [31:0] wa;
        logic [31:0] wd;
        exp_t        e;
        drive_pins();
        if (p[0] && p[1]) win = (starve_m == LIM) ? 1 : 0;
        else              win = p[1] ? 1 : 0;
        if (win == 0 && p[1]) starve_m = (starve_m < LIM) ? starve_m + 1 : LIM;
        else                  starve_m = 0;
        wa = a_r[win];
        wd = d_r[win];
        if (we_r[win]) begin
            mmem[wa[5:2]] = wd;
            writes_m++;
        end else begin
            last_rd[win] = mmem[wa[5:2]];
        end
        e.port = win; e.r0 = last_rd[0]; e.r1 = last_rd[1];
        expq.push_back(e);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (n == 2) begin
                chk("mem_en", {31'd0, mem_en}, 32'd1);
                chk("mem_addr", mem_addr, wa & 32'hFFFF_FFFC);
                chk("mem_wdata", mem_wdata, wd);
            end
            if (ack0 || ack1) break;
            if (n > 20) begin
                bad++;
                total++;
                $display("FAIL ack_timeout: no ack after %0d cycles, want %0d", n, LAT + 2);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
            if (n == 1) begin
                @(posedge clk);
                #1;
                // Scramble the granted port's inputs; the access must use the latched copy.
                if (win == 0) begin addr0 = $urandom; wdata0 = $urandom; end
                else          begin addr1 = $urandom; wdata1 = $urandom; end
            end
        end
        chk("ack_latency", n, LAT + 2);
        @(posedge clk);
        #1;
        p[win] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i] <= 32'h100 * i + 32'd5;
            mmem[i] = 32'h100 * i + 32'd5;
        end
        last_rd[0] = '0; last_rd[1] = '0;
        for (int i = 0; i < 2; i++) begin
            p[i] = 1'b0; we_r[i] = 1'b0; a_r[i] = '0; d_r[i] = '0;
        end

        #12;
        chk("rst_ack0", {31'd0, ack0}, 32'd0);
        chk("rst_ack1", {31'd0, ack1}, 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        req0 = 1'b1;
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd1);
        req0 = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_on = 1'b1;

        // Unaligned port-0 read, then port-1 write and port-0 read-back of the same word.
        new_req(0, 1'b0, 32'h0000_0007, 32'h0);
        do_access();
        new_req(1, 1'b1, 32'h0000_001c, 32'hDEAD_BEEF);
        do_access();
        new_req(0, 1'b0, 32'h0000_001c, 32'h0);
        do_access();

        // Both ports requesting continuously.
        rnd_req(0);
        rnd_req(1);
        for (int k = 0; k < 12; k++) begin
            do_access();
            if (!p[0]) rnd_req(0);
            if (!p[1]) rnd_req(1);
        end
        for (int k = 0; k < 6; k++) begin
            if (!p[0] || !p[1]) break;
            do_access();
        end
        while (p[0] || p[1]) do_access();

        // Reset during the second BUSY cycle of a port-1 write: no strobe, no ack.
        new_req(1, 1'b1, 32'h0000_0020, 32'hCAFE_F00D);
        drive_pins();
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstmid_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rstmid_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rstmid_ack1", {31'd0, ack1}, 32'd0);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_mem_addr", mem_addr, 32'd0);
        p[1] = 1'b0;
        drive_pins();
        starve_m = 0;
        last_rd[0] = '0; last_rd[1] = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        new_req(0, 1'b0, 32'h0000_0020, 32'h0);
        do_access();

        // Random traffic.
        for (int k = 0; k < 60; k++) begin
            if (!p[0] && $urandom_range(0, 1) == 1) rnd_req(0);
            if (!p[1] && $urandom_range(0, 1) == 1) rnd_req(1);
            if (!p[0] && !p[1]) rnd_req(int'($urandom_range(0, 1)));
            do_access();
        end
        while (p[0] || p[1]) do_access();

        drive_pins();
        repeat (4) @(posedge clk);
        #1;
        chk("we_pulses", we_cnt, writes_m);
        chk("queue_empty", expq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
